// File: rtl/multiplier_result_reader.sv
// ============================================================================
// Module      : multiplier_result_reader
// Description : Read side of the multiplier accelerator. Tracks which
//               round-robin thread issued a multiply, captures that thread's
//               {R_high, R_low} when it leaves the pipeline, keeps a sticky
//               per-thread ready flag and serves a 1-cycle-latency read window
//               (offset 0 = low word, 1 = high word, 2 = status).
// Options     : `define MULTIPLIER_RESULT_READER_STATUS_EN enables overrun
//               tracking and the status word at offset 2.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multiplier_result_reader #(
  parameter int WORD_WIDTH      = 36,
  parameter int THREAD_COUNT    = 8,
  parameter int PIPELINE_DEPTH  = 8,
  parameter int READ_ADDR       = 0,
  parameter int READ_ADDR_WIDTH = 10
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       issue,
  input  logic [WORD_WIDTH-1:0]      R_low,
  input  logic [WORD_WIDTH-1:0]      R_high,
  input  logic                       read_enable,
  input  logic [READ_ADDR_WIDTH-1:0] read_addr,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       read_valid,
  output logic                       result_ready
);

  localparam int                         c_TW   = (THREAD_COUNT > 1) ? $clog2(THREAD_COUNT) : 1;
  localparam logic [c_TW-1:0]            c_LAST = c_TW'(THREAD_COUNT - 1);
  localparam logic [READ_ADDR_WIDTH-1:0] c_BASE = READ_ADDR_WIDTH'(READ_ADDR);

  logic [c_TW-1:0]           r_thread;
  logic [PIPELINE_DEPTH-1:0] r_pend;
  logic [WORD_WIDTH-1:0]     r_lo [THREAD_COUNT];
  logic [WORD_WIDTH-1:0]     r_hi [THREAD_COUNT];
  logic [THREAD_COUNT-1:0]   r_ready;
`ifdef MULTIPLIER_RESULT_READER_STATUS_EN
  logic [THREAD_COUNT-1:0]   r_ovr;
`endif

  logic                       w_pend_out;
  logic [READ_ADDR_WIDTH-1:0] w_offset;
  logic                       w_in_base;
  logic                       w_rd_lo;
  logic                       w_rd_hi;
  logic                       w_rd_st;
  logic                       w_rd_hit;
  logic [WORD_WIDTH-1:0]      w_rd_word;

  // Because the pipeline depth equals the thread count, the oldest pending
  // issue always belongs to the thread that is current right now.
  assign w_pend_out = r_pend[PIPELINE_DEPTH-1];

  // Addresses below the base wrap to a large offset, but are rejected
  // explicitly so a window near the top of the space cannot alias.
  assign w_offset  = read_addr - c_BASE;
  assign w_in_base = (read_addr >= c_BASE);
  assign w_rd_lo   = read_enable && w_in_base && (w_offset == READ_ADDR_WIDTH'(0));
  assign w_rd_hi   = read_enable && w_in_base && (w_offset == READ_ADDR_WIDTH'(1));
`ifdef MULTIPLIER_RESULT_READER_STATUS_EN
  assign w_rd_st   = read_enable && w_in_base && (w_offset == READ_ADDR_WIDTH'(2));
`else
  assign w_rd_st   = 1'b0;
`endif
  assign w_rd_hit  = w_rd_lo || w_rd_hi || w_rd_st;

  assign result_ready = r_ready[r_thread];

  // Read mux: always sees pre-capture storage of the current thread.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_lo) begin
      w_rd_word = r_lo[r_thread];
    end else if (w_rd_hi) begin
      w_rd_word = r_hi[r_thread];
`ifdef MULTIPLIER_RESULT_READER_STATUS_EN
    end else if (w_rd_st) begin
      w_rd_word = WORD_WIDTH'({r_ovr[r_thread], r_ready[r_thread]});
`endif
    end
  end

  // Round-robin thread counter and in-flight issue tracking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_thread <= '0;
      r_pend   <= '0;
    end else begin
      r_thread <= (r_thread == c_LAST) ? '0 : r_thread + 1'b1;
      r_pend   <= {r_pend[PIPELINE_DEPTH-2:0], issue};
    end
  end

  // Per-thread result capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        r_lo[i] <= '0;
        r_hi[i] <= '0;
      end
    end else if (w_pend_out) begin
      r_lo[r_thread] <= R_low;
      r_hi[r_thread] <= R_high;
    end
  end

  // Sticky flags: a capture always wins over a clearing read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ready <= '0;
`ifdef MULTIPLIER_RESULT_READER_STATUS_EN
      r_ovr   <= '0;
`endif
    end else begin
      if (w_pend_out) begin
        r_ready[r_thread] <= 1'b1;
      end else if (w_rd_hi) begin
        r_ready[r_thread] <= 1'b0;
      end
`ifdef MULTIPLIER_RESULT_READER_STATUS_EN
      if (w_pend_out && r_ready[r_thread]) begin
        r_ovr[r_thread] <= 1'b1;
      end else if (w_rd_st) begin
        r_ovr[r_thread] <= 1'b0;
      end
`endif
    end
  end

  // Registered read port; misses and idle cycles return zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_data  <= w_rd_word;
      read_valid <= w_rd_hit;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multiplier_result_reader.sv
// ============================================================================
// Module      : tb_multiplier_result_reader
// Description : Scoreboard bench for multiplier_result_reader. Reads push
//               their expected response; a monitor pops and compares on the
//               cycle the registered result appears.
// Options     : honours `define MULTIPLIER_RESULT_READER_STATUS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multiplier_result_reader;

  localparam int c_WW = 36;

  typedef struct {
    logic [c_WW-1:0] d;
    logic            v;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            issue = 1'b0;
  logic [c_WW-1:0] R_low;
  logic [c_WW-1:0] R_high;
  logic            read_enable = 1'b0;
  logic [9:0]      read_addr = '0;
  logic [c_WW-1:0] read_data;
  logic            read_valid;
  logic            result_ready;

  logic [c_WW-1:0] res_lo [8];
  logic [c_WW-1:0] res_hi [8];
  int              thr = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  exp_t            q[$];
  logic            mon_rd;
  exp_t            mon_e;

  // Multiplier stand-in: each thread's result is presented whenever it is current.
  assign R_low  = res_lo[thr];
  assign R_high = res_hi[thr];

  multiplier_result_reader dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue        (issue),
    .R_low        (R_low),
    .R_high       (R_high),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .result_ready (result_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [c_WW-1:0] act, input logic [c_WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (thread %0d)", nm, act, exp, thr);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (!reset_n) thr = 0;
    else thr = (thr + 1) % 8;
  endtask

  task automatic wait_thread(input int t);
    for (int i = 0; i < 8 && thr != t; i++) tick();
    if (thr != t) begin
      n_fail++;
      $display("FAIL wait_thread: got %0d expected %0d", thr, t);
    end
  endtask

  task automatic do_read(input logic [9:0] a, input logic [c_WW-1:0] d, input logic v);
    exp_t e;
    e.d = d;
    e.v = v;
    q.push_back(e);
    read_enable = 1'b1;
    read_addr   = a;
    tick();
    read_enable = 1'b0;
    read_addr   = '0;
  endtask

  task automatic do_issue(input logic [c_WW-1:0] lo, input logic [c_WW-1:0] hi);
    res_lo[thr] = lo;
    res_hi[thr] = hi;
    issue = 1'b1;
    tick();
    issue = 1'b0;
  endtask

  // Monitor: one scoreboard entry per accepted read, zeros otherwise.
  always begin
    @(posedge clock);
    mon_rd = read_enable && reset_n;
    #1;
    if (mon_rd) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got read response, expected none");
      end else begin
        mon_e = q.pop_front();
        chk("rd_valid", {35'd0, read_valid}, {35'd0, mon_e.v});
        chk("rd_data", read_data, mon_e.d);
      end
    end else begin
      chk("idle_valid", {35'd0, read_valid}, 36'd0);
      chk("idle_data", read_data, 36'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      res_lo[i] = '0;
      res_hi[i] = '0;
    end
    // Reset state
    tick();
    tick();
    chk("rst_ready", {35'd0, result_ready}, 36'd0);
    chk("rst_valid", {35'd0, read_valid}, 36'd0);
    chk("rst_data", read_data, 36'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("idle_ready", {35'd0, result_ready}, 36'd0);
      tick();
    end
    do_read(10'd0, 36'd0, 1'b1);
    do_read(10'd1, 36'd0, 1'b1);

    // Single result on thread 3
    wait_thread(3);
    do_issue(36'h5, 36'h1);
    wait_thread(3);
    tick();
    wait_thread(3);
    chk("t3_ready", {35'd0, result_ready}, 36'd1);
    do_read(10'd0, 36'h5, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("others_ready", {35'd0, result_ready}, 36'd0);
      tick();
    end
    chk("t3_ready_kept", {35'd0, result_ready}, 36'd1);
    do_read(10'd1, 36'h1, 1'b1);
    wait_thread(3);
    chk("t3_ready_clr", {35'd0, result_ready}, 36'd0);

    // All threads back to back, starting at 4 to cross the wrap
    wait_thread(4);
    for (int i = 0; i < 8; i++) do_issue(36'(thr), 36'(thr + 'h100));
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 8; i++) do_read(10'd0, 36'(thr), 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("all_ready", {35'd0, result_ready}, 36'd1);
      do_read(10'd1, 36'(thr + 'h100), 1'b1);
    end

    // Thread 5: two captures without a read
    wait_thread(5);
    do_issue(36'hA, 36'h0);
    wait_thread(5);
    tick();
    wait_thread(5);
    do_issue(36'hB, 36'h0);
    wait_thread(5);
    tick();
    wait_thread(5);
    do_read(10'd0, 36'hB, 1'b1);
    wait_thread(5);
`ifdef MULTIPLIER_RESULT_READER_STATUS_EN
    do_read(10'd2, 36'h3, 1'b1);
    wait_thread(5);
    do_read(10'd2, 36'h1, 1'b1);
`else
    do_read(10'd2, 36'h0, 1'b0);
`endif
    wait_thread(5);
    do_read(10'd1, 36'h0, 1'b1);

    // Thread 2: read of high word collides with a new capture
    wait_thread(2);
    do_issue(36'h1, 36'h9);
    wait_thread(2);
    tick();
    wait_thread(2);
    chk("t2_ready_old", {35'd0, result_ready}, 36'd1);
    do_issue(36'h3, 36'h7);
    wait_thread(2);
    do_read(10'd1, 36'h9, 1'b1);
    wait_thread(2);
    chk("t2_ready_wins", {35'd0, result_ready}, 36'd1);
    do_read(10'd1, 36'h7, 1'b1);
    wait_thread(2);
    chk("t2_ready_clr", {35'd0, result_ready}, 36'd0);
`ifdef MULTIPLIER_RESULT_READER_STATUS_EN
    do_read(10'd2, 36'h2, 1'b1);
`else
    do_read(10'd2, 36'h0, 1'b0);
`endif

    // Thread 6: reset while the result is in flight
    wait_thread(6);
    do_issue(36'h55, 36'h66);
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_valid", {35'd0, read_valid}, 36'd0);
    chk("mid_rst_data", read_data, 36'd0);
    for (int i = 0; i < 16; i++) begin
      chk("mid_rst_ready", {35'd0, result_ready}, 36'd0);
      tick();
    end
    wait_thread(6);
    do_read(10'd0, 36'h0, 1'b1);
    do_read(10'd3, 36'h0, 1'b0);
    do_read(10'h3FF, 36'h0, 1'b0);

    tick();
    tick();
    chk("queue_empty", 36'(q.size()), 36'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
